// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO consecutive narrow valid/ready beats into one wide
// output word. Lane 0 holds the first beat. A beat with s_last_i closes a partial
// word early, and that word is marked last. The output side is fully registered.
// The only combinational input-to-output path is m_ready_i -> s_ready_o.
//
// Ports:
//   aclk        clock
//   areset_n    synchronous active-low reset
//   s_data_i    input beat (IN_WIDTH)
//   s_last_i    final beat of a packet
//   s_valid_i   input beat valid
//   s_ready_o   upsizer can accept a beat
//   m_data_o    packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH]
//   m_keep_o    lane-valid mask (RATIO)
//   m_last_o    word contains the packet's final beat
//   m_valid_o   output word valid
//   m_ready_i   downstream accepts the word
//   m_parity_o  per-lane even parity (RATIO); present only when
//               STREAM_UPSIZER_PARITY_EN is defined
module stream_upsizer #(
    parameter int unsigned IN_WIDTH = 32,
    parameter int unsigned RATIO    = 4
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic [IN_WIDTH-1:0]       s_data_i,
    input  logic                      s_last_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [IN_WIDTH*RATIO-1:0] m_data_o,
    output logic [RATIO-1:0]          m_keep_o,
    output logic                      m_last_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i
`ifdef STREAM_UPSIZER_PARITY_EN
    ,
    output logic [RATIO-1:0]          m_parity_o
`endif
);

    localparam int unsigned OutW = IN_WIDTH * RATIO;
    localparam int unsigned CntW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);
    localparam logic [RATIO-1:0] KeepLane0 = {{(RATIO-1){1'b0}}, 1'b1};

    typedef enum logic {StFill, StHold} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [OutW-1:0]     acc_q;
    logic [RATIO-1:0]    keep_q;
    logic                last_q;
`ifdef STREAM_UPSIZER_PARITY_EN
    logic [RATIO-1:0]    parity_q;
`endif

    logic in_acc;
    logic out_acc;

    assign s_ready_o = areset_n && ((state_q == StFill) || m_ready_i);
    assign m_valid_o = (state_q == StHold);
    assign in_acc    = s_valid_i && s_ready_o;
    assign out_acc   = m_valid_o && m_ready_i;

    assign m_data_o  = acc_q;
    assign m_keep_o  = keep_q;
    assign m_last_o  = last_q;
`ifdef STREAM_UPSIZER_PARITY_EN
    assign m_parity_o = parity_q;
`endif

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q  <= StFill;
            cnt_q    <= '0;
            acc_q    <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
`ifdef STREAM_UPSIZER_PARITY_EN
            parity_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StFill: begin
                    if (in_acc) begin
                        acc_q[cnt_q*IN_WIDTH +: IN_WIDTH] <= s_data_i;
                        keep_q[cnt_q] <= 1'b1;
`ifdef STREAM_UPSIZER_PARITY_EN
                        parity_q[cnt_q] <= ^s_data_i;
`endif
                        if (cnt_q == CntMax || s_last_i) begin
                            state_q <= StHold;
                            last_q  <= s_last_i;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (out_acc) begin
                        if (in_acc) begin
                            // Word leaves and the new beat opens the next one in lane 0.
                            acc_q  <= OutW'(s_data_i);
                            keep_q <= KeepLane0;
`ifdef STREAM_UPSIZER_PARITY_EN
                            parity_q <= {{(RATIO-1){1'b0}}, ^s_data_i};
`endif
                            if (s_last_i) begin
                                state_q <= StHold;
                                last_q  <= 1'b1;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= StFill;
                                last_q  <= 1'b0;
                                cnt_q   <= CntW'(1);
                            end
                        end else begin
                            state_q <= StFill;
                            acc_q   <= '0;
                            keep_q  <= '0;
                            last_q  <= 1'b0;
`ifdef STREAM_UPSIZER_PARITY_EN
                            parity_q <= '0;
`endif
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed self-checking bench for stream_upsizer (IN_WIDTH=32, RATIO=4).
module tb_stream_upsizer;

    logic         aclk;
    logic         areset_n;
    logic [31:0]  s_data_i;
    logic         s_last_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [127:0] m_data_o;
    logic [3:0]   m_keep_o;
    logic         m_last_o;
    logic         m_valid_o;
    logic         m_ready_i;
`ifdef STREAM_UPSIZER_PARITY_EN
    logic [3:0]   m_parity_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    stream_upsizer #(
        .IN_WIDTH (32),
        .RATIO    (4)
    ) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_keep_o  (m_keep_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
`ifdef STREAM_UPSIZER_PARITY_EN
        ,
        .m_parity_o (m_parity_o)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        s_valid_i = 1'b1;
        s_data_i  = data;
        s_last_i  = last;
        tick();
    endtask

    task automatic idle();
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        areset_n  = 1'b0;
        m_ready_i = 1'b0;
        idle();
        #1;
        check("rst_s_ready", 128'(s_ready_o), 128'd0);
        tick();
        tick();
        check("rst_m_valid", 128'(m_valid_o), 128'd0);
        check("rst_m_data", m_data_o, 128'd0);
        check("rst_m_keep", 128'(m_keep_o), 128'd0);
        check("rst_m_last", 128'(m_last_o), 128'd0);
        areset_n = 1'b1;
        #1;
        check("post_rst_s_ready", 128'(s_ready_o), 128'd1);

        // Full word
        m_ready_i = 1'b1;
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h33, 1'b0);
        check("full_not_yet_valid", 128'(m_valid_o), 128'd0);
        beat(32'h44, 1'b0);
        idle();
        check("full_valid", 128'(m_valid_o), 128'd1);
        check("full_data", m_data_o, pack4(32'h11, 32'h22, 32'h33, 32'h44));
        check("full_keep", 128'(m_keep_o), 128'hF);
        check("full_last", 128'(m_last_o), 128'd0);
        tick();
        check("full_drained", 128'(m_valid_o), 128'd0);

        // Early last
        beat(32'hA, 1'b0);
        beat(32'hB, 1'b1);
        idle();
        check("early_valid", 128'(m_valid_o), 128'd1);
        check("early_data", m_data_o, pack4(32'hA, 32'hB, 32'h0, 32'h0));
        check("early_keep", 128'(m_keep_o), 128'h3);
        check("early_last", 128'(m_last_o), 128'd1);
`ifdef STREAM_UPSIZER_PARITY_EN
        check("early_parity", 128'(m_parity_o), 128'h2);
`endif
        tick();
        check("early_drained", 128'(m_valid_o), 128'd0);

        // Backpressure
        m_ready_i = 1'b0;
        beat(32'h1, 1'b0);
        beat(32'h2, 1'b0);
        beat(32'h3, 1'b0);
        beat(32'h4, 1'b0);
        s_valid_i = 1'b1;
        s_data_i  = 32'h5;
        s_last_i  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_s_ready", 128'(s_ready_o), 128'd0);
            check("bp_valid", 128'(m_valid_o), 128'd1);
            check("bp_data", m_data_o, pack4(32'h1, 32'h2, 32'h3, 32'h4));
            check("bp_keep", 128'(m_keep_o), 128'hF);
            check("bp_last", 128'(m_last_o), 128'd0);
            tick();
        end
        m_ready_i = 1'b1;
        #1;
        check("bp_release_s_ready", 128'(s_ready_o), 128'd1);
        tick();
        check("bp_beat5_valid", 128'(m_valid_o), 128'd0);
        check("bp_beat5_data", m_data_o, pack4(32'h5, 32'h0, 32'h0, 32'h0));
        check("bp_beat5_keep", 128'(m_keep_o), 128'h1);
        beat(32'h6, 1'b0);
        beat(32'h7, 1'b0);
        beat(32'h8, 1'b0);
        idle();
        check("bp_word2_valid", 128'(m_valid_o), 128'd1);
        check("bp_word2_data", m_data_o, pack4(32'h5, 32'h6, 32'h7, 32'h8));
        tick();
        check("bp_drained", 128'(m_valid_o), 128'd0);

        // Streaming 1..12 with no bubble
        for (int i = 1; i <= 12; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 32'(i);
            s_last_i  = (i == 12);
            #1;
            check("stream_s_ready", 128'(s_ready_o), 128'd1);
            tick();
            if (i % 4 == 0) begin
                check("stream_word_valid", 128'(m_valid_o), 128'd1);
                check("stream_word_data", m_data_o,
                      pack4(32'(i - 3), 32'(i - 2), 32'(i - 1), 32'(i)));
                check("stream_word_keep", 128'(m_keep_o), 128'hF);
                check("stream_word_last", 128'(m_last_o), 128'(i == 12));
            end else begin
                check("stream_gap_valid", 128'(m_valid_o), 128'd0);
            end
        end

        // Overlap: word 3 held, single-beat last accepted in the same cycle
        beat(32'h55, 1'b1);
        idle();
        check("ovl_valid", 128'(m_valid_o), 128'd1);
        check("ovl_data", m_data_o, pack4(32'h55, 32'h0, 32'h0, 32'h0));
        check("ovl_keep", 128'(m_keep_o), 128'h1);
        check("ovl_last", 128'(m_last_o), 128'd1);
`ifdef STREAM_UPSIZER_PARITY_EN
        check("ovl_parity", 128'(m_parity_o), 128'h0);
`endif
        tick();
        check("ovl_drained", 128'(m_valid_o), 128'd0);

        // Reset mid-word
        beat(32'h77, 1'b0);
        beat(32'h88, 1'b0);
        idle();
        areset_n = 1'b0;
        #1;
        check("midrst_s_ready", 128'(s_ready_o), 128'd0);
        tick();
        tick();
        check("midrst_valid", 128'(m_valid_o), 128'd0);
        check("midrst_keep", 128'(m_keep_o), 128'd0);
        areset_n = 1'b1;
        beat(32'hA1, 1'b0);
        beat(32'hA2, 1'b0);
        beat(32'hA3, 1'b0);
        check("fresh_not_yet_valid", 128'(m_valid_o), 128'd0);
        beat(32'hA4, 1'b0);
        idle();
        check("fresh_valid", 128'(m_valid_o), 128'd1);
        check("fresh_data", m_data_o, pack4(32'hA1, 32'hA2, 32'hA3, 32'hA4));
        check("fresh_keep", 128'(m_keep_o), 128'hF);
`ifdef STREAM_UPSIZER_PARITY_EN
        check("fresh_parity", 128'(m_parity_o), 128'hB);
`endif
        tick();
        check("fresh_drained", 128'(m_valid_o), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Sits directly downstream of the full-throughput register slice. Consumes its narrow valid/ready stream and packs RATIO consecutive beats into one wide output word.
- Lane 0 holds the first beat.
- A beat with s_last_i high closes a partial word early and marks it last.
- The output is fully registered and sustains one input beat per cycle under continuous m_ready_i.

Parameters:
- IN_WIDTH, 32, width of one input beat in bits.
- RATIO, 4, input beats per output word. Must be at least 2.

Ports:
- aclk  input  1  clock.
- areset_n  input  1  reset, synchronous, active-low.
- s_data_i  input  IN_WIDTH  input beat.
- s_last_i  input  1  final beat of a packet.
- s_valid_i  input  1  input beat valid.
- s_ready_o  output  1  upsizer can accept a beat.
- m_data_o  output  IN_WIDTH*RATIO  packed word. Lane k is bits [k*IN_WIDTH +: IN_WIDTH].
- m_keep_o  output  RATIO  lane-valid mask. Bit k set means lane k holds a real beat.
- m_last_o  output  1  word contains the packet's final beat.
- m_valid_o  output  1  output word valid.
- m_ready_i  input  1  downstream accepts the word.

Behaviour:
- Reset: areset_n, synchronous, active-low; clock aclk. While areset_n is low, s_ready_o=0. After the reset edge: state=FILL, cnt=0, m_valid_o=0, m_data_o=0, m_keep_o=0, m_last_o=0.
- Registered state: state ∈ {FILL, HOLD}, cnt of width $clog2(RATIO), accumulator acc, keep, last.
- Input accept: s_valid_i && s_ready_o. Output accept: m_valid_o && m_ready_i.
- s_ready_o = areset_n && (state==FILL || m_ready_i). The m_ready_i term is the only combinational in-to-out path.
- m_valid_o = (state==HOLD). m_data_o, m_keep_o and m_last_o are driven directly from registers.
- FILL, on input accept:
  - write lane cnt of acc and set keep[cnt].
  - If cnt==RATIO-1 or s_last_i: go to HOLD, last<=s_last_i, cnt<=0.
  - Otherwise cnt<=cnt+1.
- FILL, no accept: hold all state.
- HOLD, no output accept: all outputs stable. Data, keep and last must not change while m_valid_o=1 and m_ready_i=0.
- HOLD, output accept without input accept: go to FILL, clear acc to 0, keep to 0, last to 0.
- HOLD, output accept with simultaneous input accept: the new beat starts the next word.
  - acc <= beat in lane 0 with all other lanes 0; keep <= 1; cnt <= 1.
  - If s_last_i: stay in HOLD with keep=...0001 and last=1, cnt=0.
  - Otherwise go to FILL.
- Unused lanes of a partial word read 0.
- Latency: the word is valid in the cycle after its final beat is accepted.
- Throughput: one beat per cycle with continuous valid/ready. No bubble between words.
- Wrap: cnt wraps RATIO-1 → 0 only through the HOLD transition, never by overflow.
- Reset mid-word or mid-HOLD: the partial word is discarded with no output.

Optional Feature:
- Macro: STREAM_UPSIZER_PARITY_EN.
- Defined:
  - Adds output m_parity_o, width RATIO. Bit k is the even parity (XOR reduction) of lane k, computed and registered when that lane is written.
  - Cleared together with acc. Reset value 0.
  - Stable under the same hold rule as m_data_o.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (IN_WIDTH=32, RATIO=4):
- Full word: beats 0x11,0x22,0x33,0x44, no last, m_ready_i=1. Expect m_valid_o=1 one cycle after the 4th beat, m_data_o=0x00000044_00000033_00000022_00000011, keep=4'b1111, last=0.
- Early last: beats 0xA, 0xB with last on 0xB. Expect m_data_o lanes 0..1 = 0xA, 0xB and lanes 2..3 = 0, keep=4'b0011, last=1.
- Backpressure: complete a word with m_ready_i=0 for 5 cycles, then present a 5th beat. Expect outputs stable for all 5 cycles, s_ready_o=0, and the 5th beat not accepted until m_ready_i=1.
- Streaming: 12 back-to-back beats 1..12 with last on 12, valid and ready always high. Expect 3 words on consecutive emission cycles with no bubble; the third has last=1 and keep=1111.
- Overlap with single-beat last: in HOLD, m_ready_i=1 and beat 0x55 with last in the same cycle. Expect next word 0x...00000055, keep=0001, last=1, and the state stays HOLD.
- Reset: assert areset_n=0 after 2 beats, then release and send 4 fresh beats. Expect no output from the discarded partial word and the first word to contain only the fresh beats. With STREAM_UPSIZER_PARITY_EN defined, lane data 0x1 gives m_parity_o bit = 1.
